// File: rtl/icache_pkg.sv
// Shared decode constants and FSM encodings for the instruction fetch unit.
package icache_pkg;

  // 32-bit major opcodes that can redirect the fetch stream
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Compressed quadrants and funct3 values for control-flow instructions
  localparam logic [1:0] RVC_Q1  = 2'b01;
  localparam logic [1:0] RVC_Q2  = 2'b10;
  localparam logic [2:0] C1_JAL  = 3'b001;
  localparam logic [2:0] C1_J    = 3'b101;
  localparam logic [2:0] C1_BEQZ = 3'b110;
  localparam logic [2:0] C1_BNEZ = 3'b111;
  localparam logic [2:0] C2_JR   = 3'b100;

  // Fetch sequencer states
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_MISS = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Static predictor modes
  localparam logic [1:0] PRED_SEQ  = 2'd0;
  localparam logic [1:0] PRED_JAL  = 2'd1;
  localparam logic [1:0] PRED_BTFN = 2'd2;

endpackage

// File: rtl/rv_static_predictor.sv
// Combinational RVC length decode and static next-PC prediction.
module rv_static_predictor
  import icache_pkg::*;
#(
  parameter bit RVC_EN = 1'b1
) (
  input  logic [31:0] pc_i,
  input  logic [31:0] inst_i,
  input  logic [1:0]  mode_i,
  output logic        rvc_o,
  output logic [31:0] pred_pc_o,
  output logic        is_indirect_o
);

  logic [31:0] seq_pc;
  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic [31:0] imm_cj;
  logic [31:0] imm_cb;
  logic [2:0]  c_f3;

  assign c_f3   = inst_i[15:13];
  assign imm_j  = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
  assign imm_b  = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign imm_cj = {{21{inst_i[12]}}, inst_i[8], inst_i[10:9], inst_i[6], inst_i[7],
                   inst_i[2], inst_i[11], inst_i[5:3], 1'b0};
  assign imm_cb = {{24{inst_i[12]}}, inst_i[6:5], inst_i[2], inst_i[11:10], inst_i[4:3], 1'b0};

  // Length decode, then override the sequential PC for predicted-taken transfers
  always_comb begin
    rvc_o         = RVC_EN && (inst_i[1:0] != 2'b11);
    seq_pc        = pc_i + (rvc_o ? 32'd2 : 32'd4);
    pred_pc_o     = seq_pc;
    is_indirect_o = 1'b0;
    if (rvc_o) begin
      if (inst_i[1:0] == RVC_Q1 && (c_f3 == C1_J || c_f3 == C1_JAL) && mode_i != PRED_SEQ)
        pred_pc_o = pc_i + imm_cj;
      if (inst_i[1:0] == RVC_Q1 && (c_f3 == C1_BEQZ || c_f3 == C1_BNEZ) &&
          mode_i == PRED_BTFN && imm_cb[31])
        pred_pc_o = pc_i + imm_cb;
      if (inst_i[1:0] == RVC_Q2 && c_f3 == C2_JR && inst_i[11:7] != 5'd0 && inst_i[6:2] == 5'd0)
        is_indirect_o = 1'b1;
    end else begin
      if (inst_i[6:0] == OP_JAL && mode_i != PRED_SEQ)
        pred_pc_o = pc_i + imm_j;
      if (inst_i[6:0] == OP_BRANCH && mode_i == PRED_BTFN && imm_b[31])
        pred_pc_o = pc_i + imm_b;
      if (inst_i[6:0] == OP_JALR)
        is_indirect_o = 1'b1;
    end
  end

endmodule

// File: rtl/icache_fetch_unit.sv
// Direct-mapped instruction cache with PC sequencer, miss fill and static prediction.
module icache_fetch_unit
  import icache_pkg::*;
#(
  parameter int unsigned NUM_LINES = 32,
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int unsigned PRED_MODE = 1,
  parameter bit          RVC_EN    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  output logic        out_rvc,
  output logic [31:0] out_pred_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        inval
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned TAG_W = 31 - IDX_W;
  localparam logic [1:0]  MODE  = 2'(PRED_MODE);

  logic [1:0]  state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic        drop_q, drop_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic        out_rvc_q, out_rvc_d;
  logic [31:0] out_pred_q, out_pred_d;

  logic [NUM_LINES-1:0] valid_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [31:0]          data_q [NUM_LINES];

  logic [IDX_W-1:0] look_idx;
  logic [IDX_W-1:0] fill_idx;
  logic [31:0]      look_data;
  logic             hit;
  logic             fill_we;
  logic             slot_free;
  logic             pred_rvc;
  logic [31:0]      pred_pc;
  logic             pred_ind;

  assign look_idx  = fetch_pc_q[IDX_W:1];
  assign fill_idx  = mem_addr_q[IDX_W:1];
  assign look_data = data_q[look_idx];
  assign hit       = valid_q[look_idx] && (tag_q[look_idx] == fetch_pc_q[31:IDX_W+1]) && !inval;
  assign fill_we   = (state_q == ST_MISS) && mem_rvalid && !inval;
  assign slot_free = !out_valid_q || out_ready;

  rv_static_predictor #(
    .RVC_EN(RVC_EN)
  ) u_pred (
    .pc_i         (fetch_pc_q),
    .inst_i       (look_data),
    .mode_i       (MODE),
    .rvc_o        (pred_rvc),
    .pred_pc_o    (pred_pc),
    .is_indirect_o(pred_ind)
  );

  // Sequencer next state: fetch on hit, fill on miss, park after indirect jumps
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    mem_addr_d  = mem_addr_q;
    drop_d      = drop_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    out_rvc_d   = out_rvc_q;
    out_pred_d  = out_pred_q;
    case (state_q)
      ST_RUN: begin
        if (slot_free) begin
          if (hit) begin
            out_valid_d = 1'b1;
            out_inst_d  = look_data;
            out_pc_d    = fetch_pc_q;
            out_rvc_d   = pred_rvc;
            out_pred_d  = pred_pc;
            fetch_pc_d  = pred_pc;
            if (pred_ind) state_d = ST_HOLD;
          end else begin
            out_valid_d = 1'b0;
            mem_addr_d  = fetch_pc_q;
            state_d     = ST_MISS;
          end
        end
      end
      ST_MISS: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (mem_rvalid) begin
          state_d = ST_RUN;
          drop_d  = 1'b0;
          // fetch_pc already holds the redirect target when the fill is being dropped
          if (!drop_q) fetch_pc_d = mem_addr_q;
        end
      end
      ST_HOLD: begin
        if (out_valid_q && out_ready) out_valid_d = 1'b0;
      end
      default: state_d = ST_RUN;
    endcase
    if (redirect_valid) begin
      out_valid_d = 1'b0;
      fetch_pc_d  = redirect_pc;
      // An outstanding fill must still be absorbed before fetching the new target
      if (state_q == ST_MISS && !mem_rvalid) begin
        state_d = ST_MISS;
        drop_d  = 1'b1;
      end else begin
        state_d = ST_RUN;
        drop_d  = 1'b0;
      end
    end
  end

  // Sequencer and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      fetch_pc_q  <= RESET_PC;
      mem_addr_q  <= '0;
      drop_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      out_rvc_q   <= 1'b0;
      out_pred_q  <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      mem_addr_q  <= mem_addr_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      out_rvc_q   <= out_rvc_d;
      out_pred_q  <= out_pred_d;
    end
  end

  // Line valid bits: invalidate wins over a coincident fill
  always_ff @(posedge clk) begin
    if (rst || inval) valid_q <= '0;
    else if (fill_we) valid_q[fill_idx] <= 1'b1;
  end

  // Tag and data storage, written only by fills
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= mem_addr_q[31:IDX_W+1];
      data_q[fill_idx] <= mem_rdata;
    end
  end

  assign mem_req     = (state_q == ST_MISS);
  assign mem_addr    = mem_addr_q;
  assign out_valid   = out_valid_q;
  assign out_inst    = out_inst_q;
  assign out_pc      = out_pc_q;
  assign out_rvc     = out_rvc_q;
  assign out_pred_pc = out_pred_q;

endmodule

// File: doc/icache_fetch_unit.md
Name: icache_fetch_unit

Overview:
- Parametrised successor to the single-config instruction cache/fetcher.
- Direct-mapped instruction cache plus PC sequencer with RVC length decode and a selectable static predictor.
- Sits between the memory arbiter (miss fills) and the decode/issue queue (valid/ready output); the ROB/branch unit redirects it.
- New versus the previous generation: configurable depth, RESET_PC and predictor mode, BTFN prediction, a real output backpressure handshake, cache invalidate, and safe redirect during an outstanding miss.

Parameters:
- NUM_LINES, 32: cache entries, power of two, >=2; IDX_W = log2(NUM_LINES).
- RESET_PC, 32'h0: fetch PC after reset.
- PRED_MODE, 1: predictor mode.
  - 0 = always sequential.
  - 1 = JAL/C.J/C.JAL taken, branches not taken.
  - 2 = mode 1 plus backward-taken/forward-not-taken for B-type, C.BEQZ and C.BNEZ.
- RVC_EN, 1: 1 = decode 16-bit instructions; 0 = every instruction is 4 bytes.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- mem_req, out, 1: miss fill request; held high until mem_rvalid.
- mem_addr, out, 32: fill address, halfword aligned.
- mem_rvalid, in, 1: fill data valid; one-cycle pulse.
- mem_rdata, in, 32: 32 bits starting at mem_addr.
- out_valid, out, 1: instruction available.
- out_ready, in, 1: downstream accepts; transfer = out_valid & out_ready.
- out_inst, out, 32: instruction; upper 16 bits are don't-care when out_rvc=1.
- out_pc, out, 32: PC of out_inst.
- out_rvc, out, 1: 16-bit instruction.
- out_pred_pc, out, 32: predicted next PC.
- redirect_valid, in, 1: mispredict or JALR resolution.
- redirect_pc, in, 32: corrected PC.
- inval, in, 1: invalidate all cache entries (fence.i).

Behaviour:
- Entry layout: valid bit, tag = pc[31:IDX_W+1], 32-bit data. Index = pc[IDX_W:1].
- Reset: fetch_pc = RESET_PC; all valids = 0; state = RUN.
  - Outputs: mem_req=0, mem_addr=0, out_valid=0, out_inst=0, out_pc=0, out_rvc=0, out_pred_pc=0.
- States:
  - RUN
  - MISS: mem_req=1
  - HOLD: waiting for redirect after JALR/C.JR/C.JALR
- RUN, when out slot free (!out_valid | out_ready):
  - Hit: next cycle out_valid=1 with entry data and fetch_pc; fetch_pc <= prediction. One instruction per cycle on consecutive hits.
  - Miss: mem_addr <= fetch_pc, go to MISS, out_valid drops after the pending transfer.
- RUN, when out slot not free: out_* held stable and fetch_pc unchanged while out_valid & !out_ready.
- MISS, on mem_rvalid: write the entry (valid=1) and return to RUN. The lookup hits the following cycle, so miss-to-output = response + 2 cycles.
- Length decode: rvc = RVC_EN & (inst[1:0] != 2'b11). Sequential next PC = pc + (rvc ? 2 : 4).
- Prediction uses 32-bit wraparound add with sign-extended immediates per the RISC-V encodings.
  - JAL: imm[20:1]. C.J/C.JAL: imm[11:1]. B: imm[12:1]. C.B*: imm[8:1].
  - Backward means sign bit = 1.
- JALR/C.JR/C.JALR:
  - Emit the instruction with out_pred_pc = sequential PC (don't-care).
  - Enter HOLD; no further fetches until redirect.
- redirect_valid (highest priority, any state):
  - Same cycle: out_valid <= 0 next cycle; fetch_pc <= redirect_pc.
  - From RUN or HOLD: go to RUN.
  - From MISS: set drop flag and stay in MISS with mem_req held.
  - On the resulting mem_rvalid: the fill is still written (its address is correct) and nothing is emitted. Then go to RUN fetching the saved redirect PC.
  - A second redirect while draining overwrites the saved PC.
- inval: clears all valids next cycle.
  - A fill completing in the same cycle is discarded (not written).
  - Lookups in the inval cycle treat the entry as a miss.
- Redirect and inval in the same cycle: both take effect.
- Reset mid-miss: drop state; an in-flight mem_rvalid after reset is ignored unless mem_req is high.

Decomposition:
- Shared package (icache_pkg):
  - opcode constants: OP_JAL, OP_JALR, OP_BRANCH
  - RVC quadrant/funct3 constants
  - state enum
  - PRED_* mode constants
- Sub-module: rv_static_predictor. Combinational; inputs pc, inst, mode; outputs rvc, pred_pc, is_indirect.

Test Plan:
- Cold miss at RESET_PC=0, NUM_LINES=8:
  - mem_req=1, mem_addr=0.
  - Respond 32'h00000013 after 3 cycles.
  - Expect out_valid=1 with out_pc=0, out_rvc=0, out_pred_pc=4.
- Backpressure: hit stream with out_ready=0 for 4 cycles.
  - out_* stable, no PC advance.
  - After release, consecutive PCs 0, 4, 8 in 3 cycles.
- RVC plus JAL: mem at 0 = 16'h4501 (c.li) → out_rvc=1, pred=2; mem at 2 = JAL +16 → pred=18.
  - Mode 0: same JAL → pred=6.
- BTFN, PRED_MODE=2: BEQ at 0x40 with imm=-8 → pred 0x38; forward imm=+8 → pred 0x44.
- Redirect during MISS: redirect_pc=0x100 while waiting.
  - Late fill is written and not emitted.
  - Next mem_addr=0x100, and a refetch of the old address hits.
- JALR → HOLD, no mem_req/out_valid until redirect 0x200; then fetch 0x200. inval, then refetch of a cached PC issues mem_req.
